// File: rtl/cpu_pkg.sv
// Shared CPU types: control-unit operation codes and immediate formats.
// CSR-immediate codes sit after CU_ERROR so the base encoding stays stable.
package cpu_pkg;

    typedef enum logic [5:0] {
        CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND,
        CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI, CU_ANDI, CU_SLLI, CU_SRLI, CU_SRAI,
        CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
        CU_SB, CU_SH, CU_SW,
        CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
        CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
        CU_ERROR,
        CU_CSRRWI, CU_CSRRSI, CU_CSRRCI
    } cuOPType;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z, FMT_ERR
    } immFmtType;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and sign/zero extension to XLEN.
// IMM_GEN_CSR_EN enables the CSR-immediate (Z) format.
module imm_decode
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  cuOPType         cu_op,
    output logic [XLEN-1:0] imm,
    output immFmtType       imm_fmt,
    output logic            err
);

    // 32-bit value already extended from the field MSB; widened to XLEN below.
    logic [31:0] raw;
    logic        unused_opcode;

    assign unused_opcode = ^instr[6:0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        raw     = '0;
        imm_fmt = FMT_ERR;
        err     = 1'b0;
        case (cu_op)
            CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU,
            CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND: begin
                imm_fmt = FMT_R;
            end
            CU_SLLI, CU_SRLI, CU_SRAI: begin
                imm_fmt = FMT_I;
                raw     = {27'b0, instr[24:20]};
            end
            CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI, CU_ANDI,
            CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU, CU_JALR: begin
                imm_fmt = FMT_I;
                raw     = {{20{instr[31]}}, instr[31:20]};
            end
            CU_SB, CU_SH, CU_SW: begin
                imm_fmt = FMT_S;
                raw     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU: begin
                imm_fmt = FMT_B;
                raw     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            CU_LUI, CU_AUIPC: begin
                imm_fmt = FMT_U;
                raw     = {instr[31:12], 12'b0};
            end
            CU_JAL: begin
                imm_fmt = FMT_J;
                raw     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
`ifdef IMM_GEN_CSR_EN
            CU_CSRRWI, CU_CSRRSI, CU_CSRRCI: begin
                imm_fmt = FMT_Z;
                raw     = {27'b0, instr[19:15]};
            end
`endif
            default: begin
                imm_fmt = FMT_ERR;
                err     = 1'b1;
            end
        endcase
    end

    assign imm = XLEN'(signed'(raw));

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate generation stage: decode at the write side, DEPTH-entry output buffer.
// Build option IMM_GEN_CSR_EN adds CSR-immediate decoding (format Z).
module imm_gen_stage
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  cuOPType         cu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output immFmtType       imm_fmt,
    output logic            err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0] dec_imm;
    immFmtType       dec_fmt;
    logic            dec_err;

    logic [XLEN-1:0] mem_imm [DEPTH];
    immFmtType       mem_fmt [DEPTH];
    logic            mem_err [DEPTH];

    logic push, pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (instr),
        .cu_op   (cu_op),
        .imm     (dec_imm),
        .imm_fmt (dec_fmt),
        .err     (dec_err)
    );

    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // NOTE: storage has no reset; count gates every read so stale data never escapes.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_imm[wr_ptr] <= dec_imm;
            mem_fmt[wr_ptr] <= dec_fmt;
            mem_err[wr_ptr] <= dec_err;
        end
    end

    // NOTE: state registers use <= so every update sees the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign imm     = out_valid ? mem_imm[rd_ptr] : '0;
    assign imm_fmt = out_valid ? mem_fmt[rd_ptr] : FMT_R;
    assign err     = out_valid ? mem_err[rd_ptr] : 1'b0;

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning output immediate width; only 32 and 64 are legal.
REQ-002 SHALL have parameter DEPTH, default 2, meaning output buffer entries; it must be a power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid, input, 1 bit: producer offers instr/cu_op.
REQ-007 SHALL have port in_ready, output, 1 bit: the stage accepts input this cycle.
REQ-008 SHALL have port instr, input, 32 bits: raw RV32 instruction word.
REQ-009 SHALL have port cu_op, input, 6 bits (cuOPType): decoded control-unit operation.
REQ-010 SHALL have port out_valid, output, 1 bit: head entry valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the head entry.
REQ-012 SHALL have port imm, output, XLEN bits: sign/zero-extended immediate of the head entry.
REQ-013 SHALL have port imm_fmt, output, 3 bits (immFmtType): format of the head entry.
REQ-014 SHALL have port err, output, 1 bit: head entry carried an unsupported cu_op.

Function
REQ-015 SHALL map formats as follows: I = loads, JALR, ALU-immediate ops; S = stores; B = branches; U = LUI/AUIPC; J = JAL; R = register ops (imm 0); ERR = all other codes (imm 0, err=1).
REQ-016 SHALL extract bits per RISC-V: I = instr[31:20]; S = {instr[31:25], instr[11:7]}; B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}; U = {instr[31:12], 12'b0}; J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-017 SHALL sign-extend from the field MSB to XLEN, including U-type for XLEN=64; for SLLI/SRLI/SRAI, imm SHALL be the zero-extended shamt instr[24:20].
REQ-018 SHALL accept a transfer on in_valid && in_ready, writing the decoded entry at the tail.
REQ-019 SHALL drive in_ready = (count < DEPTH) combinationally from registered count; no full-throughput bypass when full.
REQ-020 SHALL present data one cycle after acceptance into an empty buffer; no combinational in-to-out path.
REQ-021 SHALL pop on out_valid && out_ready; when both a push and a pop occur, count is unchanged and both complete.
REQ-022 SHALL wrap the read and write pointers modulo DEPTH; count SHALL range 0..DEPTH.
REQ-023 SHALL hold imm/imm_fmt/err stable while out_valid && !out_ready.
REQ-024 SHALL give flush priority over push and pop in the same cycle: count to 0, pointers to 0, input dropped, in_ready still reflects pre-flush count.
REQ-025 SHALL drive imm, imm_fmt and err to 0 when out_valid=0.

Reset
REQ-026 SHALL, on rst high, immediately clear count, pointers, out_valid, imm, imm_fmt, err to 0, with in_ready=1 after release.
REQ-027 SHALL discard any in-flight entries when rst is asserted mid-stream; no partial output after release.

Configuration
REQ-028 SHALL use macro IMM_GEN_CSR_EN: when defined, CU_CSRRWI/CU_CSRRSI/CU_CSRRCI decode as format Z with imm = zero-extended instr[19:15], err=0.
REQ-029 SHALL, without IMM_GEN_CSR_EN, decode those three codes as ERR (imm 0, err 1).

Structure
REQ-030 SHALL take cuOPType (including CSR-immediate codes appended after CU_ERROR) and immFmtType {R, I, S, B, U, J, Z, ERR} from shared package cpu_pkg.
REQ-031 SHALL place extraction and extension in combinational sub-module imm_decode (params XLEN), instantiated once at the write side; buffer logic resides in imm_gen_stage.

Verification
REQ-032 SHALL test: instr 0xFE20CEE3, cu_op CU_BLT -> next cycle imm 0xFFFFFFFC, fmt B, err 0.
REQ-033 SHALL test: XLEN=64, instr 0xABCDE2B7, CU_LUI -> imm 0xFFFFFFFFABCDE000, fmt U.
REQ-034 SHALL test: instr 0xFE20AC23 CU_SW, then 0x7FF00093 CU_ADDI, with out_ready=0 -> in_ready drops to 0 after 2 pushes; release yields 0xFFFFFFF8 then 0x000007FF in order.
REQ-035 SHALL test: full buffer, simultaneous push, pop and flush -> count 0, out_valid 0 next cycle, pushed entry lost.
REQ-036 SHALL test: cu_op CU_CSRRWI, instr[19:15]=5'b10101 -> imm 21, fmt Z with IMM_GEN_CSR_EN; imm 0, err 1 without.
REQ-037 SHALL test: rst asserted with 1 entry buffered, between clock edges -> out_valid 0 immediately, in_ready 1 after release.
